fetch_queue_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the RV32I core: owns the fetch PC, issues in-order

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_queue_unit_fifo.sv | 54 +++++
 rtl/fetch_queue_unit.sv | 108 ++++++++++
 tb/tb_fetch_queue_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions: widths, the canonical NOP and the
// fetch queue entry layout.
package riscv_pkg;

    localparam int          XLEN_DEF   = 32;
    localparam int          ILEN_BYTES = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous FIFO with occupancy count, flush, and a head read straight
// from the storage registers (a push is never visible in the same cycle).
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    // Popping an empty queue is a harmless no-op.
    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset || flush)
        !(push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited
// in-order requests, queues returned words with their PC for decode.
module fetch_queue_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc
);

    localparam int          CW      = $clog2(DEPTH+1);
    localparam int          EW      = XLEN + 32;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic [EW-1:0]   head_data;
    logic            head_valid;
    logic            issue;
    logic            resp;
    logic            push;
    logic            pop;
    logic            unused_addr_bits;

    assign target           = {redirect_addr[XLEN-1:2], 2'b00};
    assign unused_addr_bits = ^redirect_addr[1:0];

    // Every queued word and every outstanding request holds one credit,
    // so the queue can always absorb whatever is still in flight.
    assign credit_used = {1'b0, count} + {1'b0, inflight};
    assign imem_req    = !reset && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_addr   = fetch_pc;
    assign issue       = imem_req && imem_gnt;

    // A response with nothing outstanding belongs to a request killed by reset.
    assign resp = imem_rvalid && (inflight != '0);
    assign push = resp && (discard == '0) && !redirect_valid && !reset;

    assign head_valid = (count != '0) && !reset;
    assign pop        = head_valid && dec_ready && !redirect_valid;
    assign dec_valid  = head_valid;
    assign dec_pc     = head_valid ? head_data[EW-1:32] : RESET_VECTOR;
    assign dec_instr  = head_valid ? head_data[31:0]    : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_VECTOR;
            resp_pc  <= RESET_VECTOR;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect_valid) begin
            // Everything still outstanding after this cycle is now stale.
            fetch_pc <= target;
            resp_pc  <= target;
            inflight <= inflight - CW'(resp);
            discard  <= inflight - CW'(resp);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(ILEN_BYTES);
            end
            inflight <= inflight + CW'(issue) - CW'(resp);
            if (resp) begin
                if (discard != '0) begin
                    discard <= discard - CW'(1);
                end else begin
                    resp_pc <= resp_pc + XLEN'(ILEN_BYTES);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({resp_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    credit_a: assert property (@(posedge clk) disable iff (reset)
        (credit_used <= DEPTH_C) && (discard <= inflight));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a DEPTH=4/RV=0 and a DEPTH=8/RV=0x100 instance
// share directed stimulus; a queue-level model is compared every cycle.
module tb_fetch_queue_unit;

    localparam int          N   = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_gnt;
    logic        dec_ready;
    logic        imem_req    [N];
    logic [31:0] imem_addr   [N];
    logic        imem_rvalid [N];
    logic [31:0] imem_rdata  [N];
    logic        dec_valid   [N];
    logic [31:0] dec_instr   [N];
    logic [31:0] dec_pc      [N];

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0)) u_dut_d4 (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req[0]), .imem_addr(imem_addr[0]), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid[0]), .imem_rdata(imem_rdata[0]),
        .dec_valid(dec_valid[0]), .dec_ready(dec_ready), .dec_instr(dec_instr[0]), .dec_pc(dec_pc[0])
    );

    fetch_queue_unit #(.XLEN(32), .DEPTH(8), .RESET_VECTOR(32'h100)) u_dut_d8 (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req[1]), .imem_addr(imem_addr[1]), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid[1]), .imem_rdata(imem_rdata[1]),
        .dec_valid(dec_valid[1]), .dec_ready(dec_ready), .dec_instr(dec_instr[1]), .dec_pc(dec_pc[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    bit chk_en = 1'b0;
    int issued [N];

    // Model: requests in flight (with a stale flag) and words waiting for decode.
    logic [31:0] oq_pc    [N][$];
    bit          oq_stale [N][$];
    logic [31:0] dq_pc    [N][$];
    logic [31:0] m_fetch  [N];
    // Memory: accepted requests waiting for their response cycle.
    logic [31:0] mp_addr  [N][$];
    int          mp_due   [N][$];
    logic        s_req    [N];
    logic [31:0] s_addr   [N];

    function automatic int dep_of(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic logic [31:0] rv_of(input int i);
        return (i == 0) ? 32'h0 : 32'h100;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hA5, a[25:2]};
    endfunction

    function automatic bit exp_req(input int i);
        return !reset && !redirect_valid && ((dq_pc[i].size() + oq_pc[i].size()) < dep_of(i));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int i, input string nm);
        int n = 0;
        @(negedge clk);
        while (dec_valid[i] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_arrives"}, 32'(dec_valid[i]), 32'd1);
    endtask

    task automatic restart(input int l);
        reset = 1'b1;
        redirect_valid = 1'b0;
        lat = l;
        repeat (4) next_cycle();
        reset = 1'b0;
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            s_req[i]  = imem_req[i];
            s_addr[i] = imem_addr[i];
            if (chk_en) begin
                bit ev;
                ev = !reset && (dq_pc[i].size() > 0);
                chk($sformatf("d%0d_imem_req", i), 32'(imem_req[i]), 32'(exp_req(i)));
                if (exp_req(i)) chk($sformatf("d%0d_imem_addr", i), imem_addr[i], m_fetch[i]);
                chk($sformatf("d%0d_dec_valid", i), 32'(dec_valid[i]), 32'(ev));
                if (ev) begin
                    chk($sformatf("d%0d_dec_pc", i), dec_pc[i], dq_pc[i][0]);
                    chk($sformatf("d%0d_dec_instr", i), dec_instr[i], mem_word(dq_pc[i][0]));
                end
            end
        end
    end

    // Model update and memory responder at each active edge.
    initial begin : model_and_memory
        for (int i = 0; i < N; i++) begin
            imem_rvalid[i] = 1'b0;
            imem_rdata[i]  = '0;
            issued[i]      = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) begin : upd
                bit          er;
                bit          took;
                bit          st;
                logic [31:0] p;
                er = exp_req(i);
                took = 1'b0;
                st = 1'b0;
                p = '0;
                if (reset) begin
                    oq_pc[i].delete();
                    oq_stale[i].delete();
                    dq_pc[i].delete();
                    m_fetch[i] = rv_of(i);
                end else begin
                    if (imem_rvalid[i] && oq_pc[i].size() > 0) begin
                        took = 1'b1;
                        p = oq_pc[i].pop_front();
                        st = oq_stale[i].pop_front();
                    end
                    if (redirect_valid) begin
                        dq_pc[i].delete();
                        for (int k = 0; k < oq_stale[i].size(); k++) oq_stale[i][k] = 1'b1;
                        m_fetch[i] = {redirect_addr[31:2], 2'b00};
                    end else begin
                        if (dec_ready && dq_pc[i].size() > 0) void'(dq_pc[i].pop_front());
                        if (took && !st) dq_pc[i].push_back(p);
                        if (er && imem_gnt) begin
                            oq_pc[i].push_back(m_fetch[i]);
                            oq_stale[i].push_back(1'b0);
                            m_fetch[i] = m_fetch[i] + 32'd4;
                        end
                    end
                end
            end
            if (reset) chk_en = 1'b1;
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (s_req[i] === 1'b1 && imem_gnt) begin
                    mp_addr[i].push_back(s_addr[i]);
                    mp_due[i].push_back(cyc - 1 + lat);
                    issued[i]++;
                end
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (mp_due[i].size() > 0 && mp_due[i][0] <= cyc) begin
                    imem_rvalid[i] = 1'b1;
                    imem_rdata[i]  = mem_word(mp_addr[i].pop_front());
                    void'(mp_due[i].pop_front());
                end else begin
                    imem_rvalid[i] = 1'b0;
                    imem_rdata[i]  = 32'hDEAD_BEEF;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        imem_gnt = 1'b1;
        dec_ready = 1'b1;
        lat = 1;

        // Reset state, then streaming with a 1-cycle memory.
        repeat (4) next_cycle();
        @(negedge clk);
        chk("rst_dec_valid", 32'(dec_valid[0]), 32'd0);
        chk("rst_imem_req", 32'(imem_req[0]), 32'd0);
        chk("rst_dec_instr", dec_instr[0], NOP);
        chk("rst_dec_pc_d4", dec_pc[0], 32'h0);
        chk("rst_dec_pc_d8", dec_pc[1], 32'h100);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("t1_first_req", 32'(imem_req[0]), 32'd1);
        chk("t1_first_addr_d4", imem_addr[0], 32'h0);
        next_cycle();
        @(negedge clk);
        chk("t1_no_bypass", 32'(dec_valid[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("t1_pc%0d", k), dec_pc[0], 32'(4 * k));
            chk($sformatf("t1_instr%0d", k), dec_instr[0], 32'hA500_0000 + 32'(k));
        end
        repeat (4) next_cycle();
        imem_gnt = 1'b0;
        repeat (3) next_cycle();
        imem_gnt = 1'b1;
        repeat (6) next_cycle();

        // Decode stalled from reset: requests stop at DEPTH, head held.
        restart(1);
        dec_ready = 1'b0;
        issued[0] = 0;
        issued[1] = 0;
        repeat (20) next_cycle();
        @(negedge clk);
        chk("t2_issued_d4", 32'(issued[0]), 32'd4);
        chk("t2_issued_d8", 32'(issued[1]), 32'd8);
        chk("t2_req_off_d4", 32'(imem_req[0]), 32'd0);
        chk("t2_req_off_d8", 32'(imem_req[1]), 32'd0);
        chk("t2_head_d4", dec_pc[0], 32'h0);
        chk("t2_head_d8", dec_pc[1], 32'h100);
        next_cycle();
        dec_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            chk($sformatf("t2_rel_valid%0d", k), 32'(dec_valid[0]), 32'd1);
            chk($sformatf("t2_rel_pc%0d_d4", k), dec_pc[0], 32'(4 * k));
            chk($sformatf("t2_rel_pc%0d_d8", k), dec_pc[1], 32'h100 + 32'(4 * k));
        end
        next_cycle();

        // Latency 3: redirect with three requests in flight.
        restart(3);
        n = 0;
        while (oq_pc[0].size() != 3 && n < 30) begin
            next_cycle();
            n++;
        end
        chk("t3_three_inflight", 32'(oq_pc[0].size()), 32'd3);
        redirect_valid = 1'b1;
        redirect_addr = 32'h40;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_flushed", 32'(dec_valid[0]), 32'd0);
        wait_valid(0, "t3");
        chk("t3_pc", dec_pc[0], 32'h40);
        chk("t3_instr", dec_instr[0], 32'hA500_0010);
        next_cycle();

        // Misaligned target and a redirect that coincides with a pop.
        restart(1);
        repeat (6) next_cycle();
        redirect_valid = 1'b1;
        redirect_addr = 32'h43;
        @(negedge clk);
        chk("t4_pop_pending", 32'(dec_valid[0]), 32'd1);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_flushed", 32'(dec_valid[0]), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t4_still_empty", 32'(dec_valid[0]), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t4_pc_d4", dec_pc[0], 32'h40);
        chk("t4_pc_d8", dec_pc[1], 32'h40);
        next_cycle();

        // Back-to-back redirects with latency 3: the last one wins.
        restart(3);
        repeat (5) next_cycle();
        redirect_valid = 1'b1;
        redirect_addr = 32'h80;
        next_cycle();
        redirect_addr = 32'h200;
        next_cycle();
        redirect_valid = 1'b0;
        wait_valid(0, "t4b_d4");
        chk("t4b_pc_d4", dec_pc[0], 32'h200);
        chk("t4b_instr_d4", dec_instr[0], 32'hA500_0080);
        chk("t4b_pc_d8", dec_pc[1], 32'h200);
        next_cycle();

        // Reset and redirect in the same cycle: reset wins.
        reset = 1'b1;
        lat = 2;
        repeat (3) next_cycle();
        redirect_valid = 1'b1;
        redirect_addr = 32'h80;
        next_cycle();
        reset = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_req_d8", 32'(imem_req[1]), 32'd1);
        chk("t5_addr_d8", imem_addr[1], 32'h100);
        chk("t5_addr_d4", imem_addr[0], 32'h0);

        // Single-cycle reset with two requests in flight; late responses ignored.
        n = 0;
        while (oq_pc[0].size() != 2 && n < 30) begin
            next_cycle();
            n++;
        end
        repeat (4) next_cycle();
        chk("t6_two_inflight", 32'(oq_pc[0].size()), 32'd2);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_valid_d4", 32'(dec_valid[0]), 32'd0);
        chk("t6_valid_d8", 32'(dec_valid[1]), 32'd0);
        chk("t6_addr_d4", imem_addr[0], 32'h0);
        chk("t6_addr_d8", imem_addr[1], 32'h100);
        wait_valid(0, "t6_d4");
        chk("t6_pc_d4", dec_pc[0], 32'h0);
        chk("t6_instr_d4", dec_instr[0], 32'hA500_0000);
        chk("t6_pc_d8", dec_pc[1], 32'h100);
        chk("t6_instr_d8", dec_instr[1], 32'hA500_0040);
        repeat (8) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
